// File: rtl/branch_predictor_pkg.sv
// Shared types for the IF-stage branch target buffer: counter encoding,
// table entry layout and tag extraction.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_ctr_t;

  // Tag is stored right-justified at full width so the entry layout does not
  // depend on the table size.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    bp_ctr_t     ctr;
    logic        is_cond;
  } btb_entry_t;

  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 32'd2);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating direction counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != STRONG_T) ctr_next = bp_ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != STRONG_NT) ctr_next = bp_ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup for
// fetch, training and mispredict detection from the EX resolution port.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_cond,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  btb_entry_t     btb_q [ENTRIES];
  logic [31:0]    branch_cnt_q;
  logic [31:0]    mispred_cnt_q;

  logic [IDX-1:0] if_idx;
  logic [IDX-1:0] ex_idx;
  logic           if_hit;
  logic           ex_hit;
  bp_ctr_t        ctr_step;
  btb_entry_t     entry_d;
  logic           update_en;

  assign if_idx = if_pc[IDX+1:2];
  assign ex_idx = ex_pc[IDX+1:2];

  // Lookup; gated by resetn so predictions are not-taken for the whole reset.
  always_comb begin
    if_hit      = btb_q[if_idx].valid && (btb_q[if_idx].tag == pc_tag(if_pc, IDX));
    pred_taken  = resetn && if_hit && (btb_q[if_idx].ctr[1] || !btb_q[if_idx].is_cond);
    pred_target = pred_taken ? btb_q[if_idx].target : if_pc + 32'd4;
  end

  always_comb begin
    mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                               (ex_taken && (ex_pred_target != ex_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  end

  assign ex_hit = btb_q[ex_idx].valid && (btb_q[ex_idx].tag == pc_tag(ex_pc, IDX));

  sat_counter2 u_ctr (
    .ctr      (btb_q[ex_idx].ctr),
    .taken    (ex_taken),
    .ctr_next (ctr_step)
  );

  always_comb begin
    entry_d   = btb_q[ex_idx];
    update_en = 1'b0;
    if (ex_hit) begin
      update_en       = 1'b1;
      entry_d.is_cond = ex_is_cond;
      if (ex_is_cond) begin
        entry_d.ctr = ctr_step;
        if (ex_taken) entry_d.target = ex_target;
      end else begin
        entry_d.target = ex_target;
        entry_d.ctr    = STRONG_T;
      end
    end else if (ex_taken) begin
      // Allocate on a taken miss, evicting whatever aliases at this index.
      update_en       = 1'b1;
      entry_d.valid   = 1'b1;
      entry_d.tag     = pc_tag(ex_pc, IDX);
      entry_d.target  = ex_target;
      entry_d.ctr     = ex_is_cond ? WEAK_T : STRONG_T;
      entry_d.is_cond = ex_is_cond;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid   <= 1'b0;
        btb_q[i].tag     <= '0;
        btb_q[i].target  <= '0;
        btb_q[i].ctr     <= WEAK_NT;
        btb_q[i].is_cond <= 1'b0;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (ex_valid) begin
      if (update_en) btb_q[ex_idx] <= entry_d;
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle stimulus and
// pre-edge expectations, plus an asynchronous mid-training reset sequence.
module tb_branch_predictor;

  logic        clk;
  logic        resetn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_cond;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_cond     (ex_is_cond),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_cond;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_mp;
    logic [31:0] e_rd;
    logic [31:0] e_bc;
    logic [31:0] e_mc;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t idle(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                                input logic [31:0] bc, input logic [31:0] mc);
    vec_t r;
    r = '{pc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pt, ptg, 1'b0, 32'h0, bc, mc};
    return r;
  endfunction

  function automatic vec_t res(input logic [31:0] pc, input logic [31:0] xpc, input logic cond,
                               input logic tk, input logic [31:0] tgt, input logic ppt,
                               input logic [31:0] pptg, input logic pt, input logic [31:0] ptg,
                               input logic mp, input logic [31:0] rd, input logic [31:0] bc,
                               input logic [31:0] mc);
    vec_t r;
    r = '{pc, 1'b1, xpc, cond, tk, tgt, ppt, pptg, pt, ptg, mp, rd, bc, mc};
    return r;
  endfunction

  task automatic drive_idle();
    ex_valid = 1'b0; ex_pc = '0; ex_is_cond = 1'b0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  initial begin
    // Index = pc[5:2]; 0x100, 0x140, 0x200 all alias at index 0.
    vecs.push_back(idle(32'h100, 0, 32'h104, 0, 0));
    vecs.push_back(res(32'h100, 32'h100, 1, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 0, 0));
    vecs.push_back(res(32'h100, 32'h100, 1, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80, 1, 1));
    vecs.push_back(res(32'h100, 32'h100, 1, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80, 2, 1));
    vecs.push_back(res(32'h100, 32'h100, 1, 1, 32'h80, 1, 32'h80, 1, 32'h80, 0, 32'h80, 3, 1));
    vecs.push_back(res(32'h100, 32'h100, 1, 0, 32'hABC0, 1, 32'h80, 1, 32'h80, 1, 32'h104, 4, 1));
    vecs.push_back(idle(32'h100, 1, 32'h80, 5, 2));
    vecs.push_back(res(32'h100, 32'h100, 1, 0, 32'hABC0, 1, 32'h80, 1, 32'h80, 1, 32'h104, 5, 2));
    vecs.push_back(idle(32'h100, 0, 32'h104, 6, 3));
    vecs.push_back(res(32'h200, 32'h200, 0, 1, 32'h40, 0, 32'h204, 0, 32'h204, 1, 32'h40, 6, 3));
    vecs.push_back(idle(32'h200, 1, 32'h40, 7, 4));
    vecs.push_back(res(32'h200, 32'h200, 0, 1, 32'h60, 1, 32'h40, 1, 32'h40, 1, 32'h60, 7, 4));
    vecs.push_back(idle(32'h200, 1, 32'h60, 8, 5));
    vecs.push_back(res(32'h100, 32'h100, 1, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 32'h80, 8, 5));
    vecs.push_back(idle(32'h100, 1, 32'h80, 9, 6));
    vecs.push_back(res(32'h140, 32'h140, 1, 1, 32'h90, 0, 32'h144, 0, 32'h144, 1, 32'h90, 9, 6));
    vecs.push_back(idle(32'h100, 0, 32'h104, 10, 7));
    vecs.push_back(idle(32'h140, 1, 32'h90, 10, 7));
    vecs.push_back(res(32'h140, 32'h140, 1, 0, 32'h90, 1, 32'h90, 1, 32'h90, 1, 32'h144, 10, 7));
    vecs.push_back(idle(32'h140, 0, 32'h144, 11, 8));
    vecs.push_back(res(32'h304, 32'h304, 1, 0, 32'h500, 0, 32'h308, 0, 32'h308, 0, 32'h308, 11, 8));
    vecs.push_back(idle(32'h304, 0, 32'h308, 12, 8));
    vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0, 12, 8));

    resetn = 1'b0;
    if_pc  = 32'h100;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if_pc          = v.if_pc;
      ex_valid       = v.ex_valid;
      ex_pc          = v.ex_pc;
      ex_is_cond     = v.ex_is_cond;
      ex_taken       = v.ex_taken;
      ex_target      = v.ex_target;
      ex_pred_taken  = v.ex_pred_taken;
      ex_pred_target = v.ex_pred_target;
      #1;
      check($sformatf("v%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, v.e_pt});
      check($sformatf("v%0d pred_target", i), pred_target, v.e_ptg);
      check($sformatf("v%0d mispredict", i), {31'b0, mispredict}, {31'b0, v.e_mp});
      if (v.ex_valid) check($sformatf("v%0d redirect_pc", i), redirect_pc, v.e_rd);
      check($sformatf("v%0d branch_cnt", i), branch_cnt, v.e_bc);
      check($sformatf("v%0d mispred_cnt", i), mispred_cnt, v.e_mc);
      @(posedge clk);
      #1;
    end

    // Train a JAL at 0x208 (index 2), then reset asynchronously mid-update.
    if_pc = 32'h208;
    ex_valid = 1'b1; ex_pc = 32'h208; ex_is_cond = 1'b0; ex_taken = 1'b1;
    ex_target = 32'h44; ex_pred_taken = 1'b0; ex_pred_target = 32'h20C;
    @(posedge clk);
    #1;
    ex_pc = 32'h100; ex_is_cond = 1'b1; ex_taken = 1'b1; ex_target = 32'h80;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h104;
    #1;
    check("pre-reset pred_taken", {31'b0, pred_taken}, 32'd1);
    check("pre-reset pred_target", pred_target, 32'h44);
    check("pre-reset branch_cnt", branch_cnt, 32'd13);
    check("pre-reset mispred_cnt", mispred_cnt, 32'd9);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset pred_taken", {31'b0, pred_taken}, 32'd0);
    check("async reset pred_target", pred_target, 32'h20C);
    check("async reset branch_cnt", branch_cnt, 32'd0);
    check("async reset mispred_cnt", mispred_cnt, 32'd0);
    check("async reset mispredict comb", {31'b0, mispredict}, 32'd1);
    @(posedge clk);
    #1;
    check("in reset branch_cnt", branch_cnt, 32'd0);
    check("in reset pred_taken", {31'b0, pred_taken}, 32'd0);
    drive_idle();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("post reset 0x208 pred_taken", {31'b0, pred_taken}, 32'd0);
    check("post reset 0x208 pred_target", pred_target, 32'h20C);
    if_pc = 32'h140;
    #1;
    check("post reset 0x140 pred_taken", {31'b0, pred_taken}, 32'd0);
    check("post reset 0x140 pred_target", pred_target, 32'h144);
    @(posedge clk);
    #1;
    check("post reset branch_cnt", branch_cnt, 32'd0);
    check("post reset mispred_cnt", mispred_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Branch target buffer with 2-bit saturating direction counters, sitting in the IF stage of the 5-stage core beside the instruction memory. It drives the next-PC choice from `pc_out` every cycle. It is trained by branches and jumps resolved in EX. Same-cycle mispredict detection and a redirect PC let the pipeline flush IF/ID.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, at least 2; `IDX = $clog2(ENTRIES)`.
- `clk`  input  1  core clock; all state updates on the rising edge.
- `resetn`  input  1  reset, asynchronous, active-low.
- `if_pc`  input  32  current fetch PC (word aligned).
- `pred_taken`  output  1  prediction for `if_pc`: redirect fetch.
- `pred_target`  output  32  predicted next PC for `if_pc`.
- `ex_valid`  input  1  a control-transfer instruction resolves in EX this cycle.
- `ex_pc`  input  32  PC of the resolving instruction.
- `ex_is_cond`  input  1  1 = conditional branch; 0 = unconditional JAL.
- `ex_taken`  input  1  actual direction; always 1 when `ex_is_cond`=0.
- `ex_target`  input  32  actual taken target.
- `ex_pred_taken`  input  1  prediction carried down the pipe with this instruction.
- `ex_pred_target`  input  32  predicted target carried down the pipe.
- `mispredict`  output  1  flush request for IF/ID.
- `redirect_pc`  output  32  correct next PC when `mispredict`=1.
- `branch_cnt`  output  32  resolved control transfers since reset.
- `mispred_cnt`  output  32  mispredictions since reset.

## Operation
- Entry fields: `valid`, `tag` = pc[31:IDX+2], `target`[31:0], `ctr`[1:0], `is_cond`. Index = pc[IDX+1:2].
- Lookup (combinational on `if_pc`):
  - Hit = valid and tag match.
  - `pred_taken` = hit and (`ctr`[1] or not `is_cond`).
  - `pred_target` = `target` if `pred_taken`, else `if_pc`+4 (32-bit, wraps at 2^32).
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Increments on taken and decrements on not-taken.
  - Saturates at 11 and at 00; it never wraps.
- Update, when `ex_valid`=1 at the clock edge:
  - Hit on `ex_pc`, conditional: counter steps toward `ex_taken`; `target` is written with `ex_target` only if `ex_taken`.
  - Hit on `ex_pc`, JAL: `target` is rewritten; `ctr` is held at 11.
  - Miss, `ex_taken`=1: allocate the entry, overwriting whatever is at the index. Set `valid`=1, `tag`, `target`=`ex_target`, `is_cond`=`ex_is_cond`. Set `ctr`=10 for conditional, 11 for JAL.
  - Miss, `ex_taken`=0: no allocation; the table is unchanged.
- Misprediction (combinational):
  - `mispredict` = `ex_valid` and (`ex_pred_taken` != `ex_taken`, or (`ex_taken` and `ex_pred_target` != `ex_target`)).
  - `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4. It is valid whenever `ex_valid`=1.
- Statistics:
  - `branch_cnt` increments on every `ex_valid` edge.
  - `mispred_cnt` increments when `mispredict`=1 at that edge.
  - Both wrap modulo 2^32.

## Timing
- Lookup latency: 0 cycles; outputs follow `if_pc` combinationally.
- Training takes effect at the edge closing the `ex_valid` cycle. A lookup of the same index in that cycle sees the pre-update entry; there is no write-to-read bypass.
- `mispredict`/`redirect_pc`: same cycle as `ex_valid`, with no registering inside this block.
- Only one update per cycle is possible: the single EX resolution port.
- Reset, asynchronous assertion at any time, including mid-training:
  - All `valid` bits clear and all `ctr` values go to 01.
  - `branch_cnt` = `mispred_cnt` = 0.
  - Tag and target contents are don't-care.
- Outputs while `resetn`=0: `pred_taken`=0, `pred_target`=`if_pc`+4. `mispredict` still follows its combinational definition; the pipeline ignores it during reset.
- Release of `resetn` is synchronised externally.

## Structure
- Add to `control_types.sv`:
  - `bp_ctr_t` enum (`STRONG_NT`, `WEAK_NT`, `WEAK_T`, `STRONG_T`).
  - `btb_entry_t` packed struct.
- Table: flop array of `btb_entry_t` (not a RAM macro), so that reset can clear the valid bits.
- Sub-module `sat_counter2`: combinational next-state for a 2-bit saturating counter (inputs `ctr`, `taken`; output next `ctr`).

## Test plan
- Reset, then `if_pc`=0x100 -> `pred_taken`=0, `pred_target`=0x104; `branch_cnt`=`mispred_cnt`=0.
- Resolve cond branch, `ex_pc`=0x100, taken, `ex_target`=0x80, `ex_pred_taken`=0:
  - Same cycle: `mispredict`=1, `redirect_pc`=0x80.
  - Next cycle with `if_pc`=0x100: `pred_taken`=1, `pred_target`=0x80.
  - `mispred_cnt`=1.
- Counter saturation at 0x100 (entry already allocated by the previous scenario):
  - Taken twice more -> `ctr`=11; taken again -> stays 11.
  - Not-taken once -> 10, still predicts taken.
  - Not-taken again -> 01, `pred_taken`=0.
- JAL at 0x200 to 0x40 -> allocated with `ctr`=11. A JAL later at 0x200 to 0x60 -> target becomes 0x60, `ctr` stays 11.
- Aliasing with `ENTRIES`=16: train 0x100 taken to 0x80, then train 0x140 (same index, different tag) taken to 0x90.
  - `if_pc`=0x100 -> miss, predicts 0x104.
  - Same-cycle lookup during an update sees the old entry.
- Assert `resetn` low asynchronously mid-clock-period while `ex_valid`=1 -> all predictions return to not-taken and both counters read 0 immediately, without waiting for an edge.
